// File: rtl/write_master_ctrl.sv
// Avalon-MM write master: streams 6-word pixel batches from an upstream buffer to SDRAM.
// Optional response timeout enabled with `define WRITE_MASTER_TIMEOUT_EN.
module write_master_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_PIXELS = 307200,
  parameter int unsigned BATCH_LEN  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        batch_ready,
  input  logic [31:0] wr_data,
  input  logic        master_waitrequest,
  input  logic        master_writeresponsevalid,
  output logic        master_write,
  output logic [31:0] master_address,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_BATCH, WRITE, WAIT_RESP, FRAME_END} state_t;

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [18:0] pix_cnt;
  logic [2:0]  word_cnt;
  logic        pending;
  logic        resp;
  logic        timeout;
  logic        batch_last;
  logic        frame_more;
  logic        br_busy;

  assign resp       = master_writeresponsevalid;
  assign batch_last = 32'(word_cnt) >= 32'(BATCH_LEN - 1);
  assign frame_more = (32'(pix_cnt) + 32'd1) < 32'(NUM_PIXELS);
  // batch_ready outside IDLE/WAIT_BATCH must be parked in pending
  assign br_busy    = batch_ready &&
                      (state == WRITE || state == WAIT_RESP || state == FRAME_END);

`ifdef WRITE_MASTER_TIMEOUT_EN
  logic [9:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RESP || resp) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 10'd1;
  end

  // to_cnt==1022 marks the 1023rd silent cycle in WAIT_RESP
  assign timeout = (state == WAIT_RESP) && !resp && (to_cnt == 10'd1022);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = WAIT_BATCH;
      WAIT_BATCH: if (batch_ready || pending) state_nx = WRITE;
      WRITE:      if (!master_waitrequest) state_nx = WAIT_RESP;
      WAIT_RESP: begin
        if (timeout)          state_nx = IDLE;
        else if (resp) begin
          if (!batch_last)      state_nx = WRITE;
          else if (frame_more)  state_nx = WAIT_BATCH;
          else                  state_nx = FRAME_END;
        end
      end
      FRAME_END:  state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      pix_cnt  <= '0;
      word_cnt <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          addr    <= BASE_ADDR;
          pix_cnt <= '0;
        end
        WAIT_BATCH: if (batch_ready || pending) word_cnt <= '0;
        WAIT_RESP: if (resp) begin
          addr     <= addr + 32'd4;
          pix_cnt  <= pix_cnt + 19'd1;
          word_cnt <= word_cnt + 3'd1;
        end
        default: ;
      endcase

      if (state_nx == IDLE || state == WAIT_BATCH) pending <= 1'b0;
      else if (br_busy)                            pending <= 1'b1;

      if ((br_busy && pending) || timeout) overrun <= 1'b1;
    end
  end

  assign master_write      = !rst && (state == WRITE);
  assign master_address    = rst ? 32'd0 : addr;
  assign master_writedata  = rst ? 32'd0 : wr_data;
  assign master_byteenable = 4'b0111;
  assign busy              = !rst && (state != IDLE);
  assign frame_done        = !rst && (state == FRAME_END);

endmodule

// File: tb/tb_write_master_ctrl.sv
// Scoreboard bench for write_master_ctrl: stimulus pushes expected writes, a monitor pops them.
module tb_write_master_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        batch_ready = 1'b0;
  logic [31:0] wr_data;
  logic        master_waitrequest = 1'b0;
  logic        master_writeresponsevalid = 1'b0;
  logic        master_write;
  logic [31:0] master_address;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          fd_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [15:0] data_idx = '0;
  bit          resp_en = 1'b1;

  // upstream buffer model: word index advances on each acknowledge
  assign wr_data = {8'h00, 8'hA5, data_idx};

  always #5 clk = ~clk;

  write_master_ctrl #(.BASE_ADDR(32'h0), .NUM_PIXELS(12), .BATCH_LEN(6)) dut (
    .clk(clk), .rst(rst), .start(start), .batch_ready(batch_ready), .wr_data(wr_data),
    .master_waitrequest(master_waitrequest),
    .master_writeresponsevalid(master_writeresponsevalid),
    .master_write(master_write), .master_address(master_address),
    .master_writedata(master_writedata), .master_byteenable(master_byteenable),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pdata(input int k);
    return {8'h00, 8'hA5, 16'(k)};
  endfunction

  task automatic push_words(input int first, input int n);
    for (int k = first; k < first + n; k++) exp_q.push_back('{addr: 32'(k * 4), data: pdata(k)});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; data_idx = '0;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_br();
    batch_ready = 1'b1;
    @(posedge clk); #1 batch_ready = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_cnt < target && n < 400) begin @(posedge clk); #1; n++; end
    chk(name, 32'(resp_cnt), 32'(target));
  endtask

  task automatic wait_wr_addr(input logic [31:0] a, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(master_write && master_address == a) && n < 400);
    chk(name, 32'(master_write && master_address == a), 32'd1);
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!frame_done && n < 400);
    chk(name, 32'(frame_done), 32'd1);
  endtask

  // monitor: every accepted write must match the head of the scoreboard
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst && master_write && !master_waitrequest) begin
      acc_cnt++;
      last_addr = master_address;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h want none", master_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", master_address, mon_e.addr);
        chk("wr_data", master_writedata, mon_e.data);
        chk("byteenable", 32'(master_byteenable), 32'h7);
      end
    end
  end

  // slave responder: acknowledge arrives 2 cycles after each accepted write
  initial forever begin
    @(negedge clk);
    if (!rst && master_write && !master_waitrequest) begin
      @(posedge clk); @(posedge clk); #1;
      if (resp_en) begin
        master_writeresponsevalid = 1'b1;
        @(posedge clk); #1 master_writeresponsevalid = 1'b0;
        data_idx = data_idx + 16'd1;
        resp_cnt++;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    cyc(2);
    @(negedge clk);
    chk("rst_write", 32'(master_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", master_address, 32'd0);
    chk("rst_data", master_writedata, 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // stray acknowledge while idle must not move anything
    master_writeresponsevalid = 1'b1;
    @(posedge clk); #1 master_writeresponsevalid = 1'b0;

    // first batch, no stalls
    push_words(0, 6);
    pulse_start();
    pulse_br();
    wait_resp(6, "batch1_resp");
    cyc(2);
    @(negedge clk);
    chk("wait_batch_busy", 32'(busy), 32'd1);
    chk("wait_batch_idle_bus", 32'(master_write), 32'd0);
    chk("batch1_drained", 32'(exp_q.size()), 32'd0);
    chk("batch1_no_fd", 32'(fd_cnt), 32'd0);

    // stray acknowledge in WAIT_BATCH
    @(posedge clk); #1 master_writeresponsevalid = 1'b1;
    @(posedge clk); #1 master_writeresponsevalid = 1'b0;

    // second batch with a 5-cycle stall on word 0
    push_words(6, 6);
    master_waitrequest = 1'b1;
    pulse_br();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_write", 32'(master_write), 32'd1);
      chk("stall_addr", master_address, 32'h18);
      chk("stall_data", master_writedata, pdata(6));
    end
    @(posedge clk); #1 master_waitrequest = 1'b0;
    wait_fd("frame_done1");
    chk("frame_end_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("fd_single", 32'(frame_done), 32'd0);
    chk("frame1_writes", 32'(acc_cnt), 32'd12);
    chk("frame1_last_addr", last_addr, 32'h2C);
    chk("frame1_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("frame1_overrun", 32'(overrun), 32'd0);

    // early batch_ready on word 2 -> pending, on word 4 -> overrun
    cyc(2);
    push_words(0, 12);
    pulse_start();
    pulse_br();
    wait_wr_addr(32'h8, "reach_word2");
    @(posedge clk); #1;
    pulse_br();
    chk("pending_no_overrun", 32'(overrun), 32'd0);
    wait_wr_addr(32'h10, "reach_word4");
    @(posedge clk); #1;
    pulse_br();
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_fd("frame_done2");
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("frame2_writes", 32'(acc_cnt), 32'd24);
    chk("frame2_drained", 32'(exp_q.size()), 32'd0);

    // reset while waiting for the word-3 acknowledge
    cyc(3);
    push_words(0, 4);
    pulse_start();
    pulse_br();
    wait_wr_addr(32'hC, "reach_word3");
    @(posedge clk); #1;
    resp_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_write", 32'(master_write), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", master_address, 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_drained", 32'(exp_q.size()), 32'd0);

    // fresh frame after reset restarts at BASE_ADDR
    resp_en = 1'b1;
    @(posedge clk); #1;
    push_words(0, 12);
    pulse_start();
    pulse_br();
    wait_resp(resp_cnt + 6, "frame3_batch1");
    pulse_br();
    wait_fd("frame_done3");
    chk("frame3_last_addr", last_addr, 32'h2C);
    chk("frame3_drained", 32'(exp_q.size()), 32'd0);
    cyc(2);
    chk("total_fd", 32'(fd_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
